// File: rtl/fdiv_driver.sv
// rtl/fdiv_driver.sv - operand FIFO and one-at-a-time request sequencer for an external fdiv unit
// Optional FDIV_DRV_TIMEOUT_EN: abort a WAIT lasting TIMEOUT cycles with a quiet-NaN error result.
module fdiv_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x1,
    input  logic [31:0] in_x2,
    output logic        div_en,
    output logic [31:0] div_x1,
    output logic [31:0] div_x2,
    input  logic [31:0] div_y,
    input  logic        div_done,
    input  logic        div_busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic        out_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("fdiv_driver: DEPTH must be a power of 2 in 2..16 and TIMEOUT at least 1");
    end

    logic [1:0]    state;
    logic [31:0]   mem_x1 [DEPTH];
    logic [31:0]   mem_x2 [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = (state == S_IDLE) && !empty && !div_busy;
    assign div_en    = (state == S_ISSUE);
    assign out_valid = (state == S_HOLD);

    // Storage carries no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x1[wr_ptr] <= in_x1;
            mem_x2[wr_ptr] <= in_x2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FDIV_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;
    logic          timeout_hit;
    logic          err_q;

    // Fires on the TIMEOUT-th consecutive WAIT cycle without a completion.
    assign timeout_hit = (state == S_WAIT) && !div_done && ((tcnt + TW'(1)) == TW'(TIMEOUT));
    assign out_err     = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                tcnt <= '0;
            end else if (state == S_WAIT && !div_done && !timeout_hit) begin
                tcnt <= tcnt + TW'(1);
            end
            if (state == S_WAIT && div_done) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            div_x1 <= '0;
            div_x2 <= '0;
            out_y  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        div_x1 <= mem_x1[rd_ptr];
                        div_x2 <= mem_x2[rd_ptr];
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (div_done) begin
                        out_y <= div_y;
                        state <= S_HOLD;
                    end
`ifdef FDIV_DRV_TIMEOUT_EN
                    else if (timeout_hit) begin
                        out_y <= 32'h7FC0_0000;
                        state <= S_HOLD;
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
